// File: rtl/clock_pkg.sv
// Shared types and constants for the clock display block.
// Holds the conversion FSM states, the time-base constants and the
// active-low seven-segment patterns. The segment bit order is
// seg[0]=CA .. seg[6]=CG, and a 0 lights the segment.
package clock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DIV_H,
        DIV_M,
        SPLIT,
        LOAD
    } state_e;

    localparam int SECS_PER_HOUR = 3600;
    localparam int SECS_PER_MIN  = 60;
    localparam int DAY_SECS      = 86400;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;  // segment G only

    // Codes above 9 decode to a dark digit.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/clock_display_if.sv
// Signal bundle between the seconds counter / board pins and clock_display.
//   secs    : seconds since midnight (driven by the counter stage)
//   an      : digit enables, active-low, an[0] = rightmost digit
//   seg     : segments, active-low
//   dp      : decimal point, active-low
//   hms_bcd : {h_t,h_u,m_t,m_u,s_t,s_u}, last converted value
//   busy    : conversion in progress
interface clock_display_if #(
    parameter int SECS_W = 17
);
    logic [SECS_W-1:0] secs;
    logic [7:0]        an;
    logic [6:0]        seg;
    logic              dp;
    logic [23:0]       hms_bcd;
    logic              busy;

    modport master (output secs, input an, seg, dp, hms_bcd, busy);
    modport slave  (input secs, output an, seg, dp, hms_bcd, busy);
endinterface

// File: rtl/clock_display_seg_scan.sv
// Multiplexed 8-digit seven-segment scanner.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   hms_bcd_i  : six BCD digits, digit 0 in the low nibble
//   err_i      : show dashes instead of the time
//   an_o       : digit enables, active-low
//   seg_o      : segments, active-low
//   dp_o       : decimal point, active-low (separators on digits 2 and 4)
// Each digit is held for SCAN_DIV clocks; digits 6 and 7 stay dark.
module seg_scan
    import clock_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] hms_bcd_i,
    input  logic        err_i,
    output logic [7:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q;
    logic [3:0]       digit;
    logic [7:0]       an_d;
    logic [6:0]       seg_d;
    logic             dp_d;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        digit = 4'h0;
        an_d  = 8'hFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        case (idx_q)
            3'd0:    digit = hms_bcd_i[3:0];
            3'd1:    digit = hms_bcd_i[7:4];
            3'd2:    digit = hms_bcd_i[11:8];
            3'd3:    digit = hms_bcd_i[15:12];
            3'd4:    digit = hms_bcd_i[19:16];
            3'd5:    digit = hms_bcd_i[23:20];
            default: digit = 4'h0;
        endcase
        if (idx_q < 3'd6) begin
            an_d = ~(8'h01 << idx_q);
            if (err_i) begin
                seg_d = SEG_DASH;
            end else begin
                seg_d = bcd_to_seg(digit);
                dp_d  = !((idx_q == 3'd2) || (idx_q == 3'd4));
            end
        end
    end

    // an/seg/dp share one register stage so they switch on the same edge.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            idx_q <= '0;
            an_o  <= 8'hFF;
            seg_o <= SEG_BLANK;
            dp_o  <= 1'b1;
        end else begin
            if (cnt_q == CNT_MAX) begin
                cnt_q <= '0;
                idx_q <= idx_q + 3'd1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            an_o  <= an_d;
            seg_o <= seg_d;
            dp_o  <= dp_d;
        end
    end

endmodule

// File: rtl/clock_display.sv
// Seconds-of-day to HH:MM:SS converter and display driver.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : clock_display_if slave (secs in; an/seg/dp/hms_bcd/busy out)
// A repeated-subtraction FSM divides secs by 3600 and 60, then splits each
// field into tens/units. hms_bcd and busy are registered one stage behind
// the FSM so they change together on the edge after LOAD.
module clock_display
    import clock_pkg::*;
#(
    parameter int SECS_W   = 17,
    parameter int SCAN_DIV = 100000,
    parameter int DAY_SECS = clock_pkg::DAY_SECS
) (
    input  logic            clk,
    input  logic            reset,
    clock_display_if.slave  bus
);

    localparam logic [SECS_W-1:0] HOUR      = SECS_W'(SECS_PER_HOUR);
    localparam logic [SECS_W-1:0] MIN       = SECS_W'(SECS_PER_MIN);
    localparam logic [SECS_W-1:0] DAY_LIMIT = SECS_W'(DAY_SECS);

    state_e            state_q, state_d;
    logic [SECS_W-1:0] captured_q, captured_d;
    logic [SECS_W-1:0] rem_q, rem_d;
    logic [4:0]        h_q, h_d;
    logic [5:0]        m_q, m_d;
    logic [5:0]        s_q, s_d;
    logic [2:0]        ht_q, ht_d, mt_q, mt_d, st_q, st_d;
    logic              err_q, err_d;
    logic              force_q, force_d;

    logic              busy_q, done_q, disp_err_q;
    logic [23:0]       hms_bcd_q;

    always_comb begin
        state_d    = state_q;
        captured_d = captured_q;
        rem_d      = rem_q;
        h_d        = h_q;
        m_d        = m_q;
        s_d        = s_q;
        ht_d       = ht_q;
        mt_d       = mt_q;
        st_d       = st_q;
        err_d      = err_q;
        force_d    = force_q;
        case (state_q)
            IDLE: begin
                // Changes on secs while busy are picked up here afterwards.
                if (force_q || (bus.secs != captured_q)) begin
                    captured_d = bus.secs;
                    rem_d      = bus.secs;
                    h_d        = '0;
                    m_d        = '0;
                    s_d        = '0;
                    ht_d       = '0;
                    mt_d       = '0;
                    st_d       = '0;
                    force_d    = 1'b0;
                    if (bus.secs >= DAY_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = LOAD;
                    end else begin
                        err_d   = 1'b0;
                        state_d = DIV_H;
                    end
                end
            end
            DIV_H: begin
                if (rem_q >= HOUR) begin
                    rem_d = rem_q - HOUR;
                    h_d   = h_q + 5'd1;
                end else begin
                    state_d = DIV_M;
                end
            end
            DIV_M: begin
                if (rem_q >= MIN) begin
                    rem_d = rem_q - MIN;
                    m_d   = m_q + 6'd1;
                end else begin
                    s_d     = rem_q[5:0];
                    state_d = SPLIT;
                end
            end
            SPLIT: begin
                if (h_q >= 5'd10) begin
                    h_d  = h_q - 5'd10;
                    ht_d = ht_q + 3'd1;
                end
                if (m_q >= 6'd10) begin
                    m_d  = m_q - 6'd10;
                    mt_d = mt_q + 3'd1;
                end
                if (s_q >= 6'd10) begin
                    s_d  = s_q - 6'd10;
                    st_d = st_q + 3'd1;
                end
                if ((h_q < 5'd10) && (m_q < 6'd10) && (s_q < 6'd10))
                    state_d = LOAD;
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            captured_q <= '0;
            rem_q      <= '0;
            h_q        <= '0;
            m_q        <= '0;
            s_q        <= '0;
            ht_q       <= '0;
            mt_q       <= '0;
            st_q       <= '0;
            err_q      <= 1'b0;
            force_q    <= 1'b1;  // convert whatever secs holds after reset
        end else begin
            state_q    <= state_d;
            captured_q <= captured_d;
            rem_q      <= rem_d;
            h_q        <= h_d;
            m_q        <= m_d;
            s_q        <= s_d;
            ht_q       <= ht_d;
            mt_q       <= mt_d;
            st_q       <= st_d;
            err_q      <= err_d;
            force_q    <= force_d;
        end
    end

    // Output stage: done_q marks the edge after LOAD. An out-of-range value
    // keeps the previous hms_bcd and only switches the display to dashes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            disp_err_q <= 1'b0;
            hms_bcd_q  <= '0;
        end else begin
            busy_q <= (state_q != IDLE);
            done_q <= (state_q == LOAD);
            if (done_q) begin
                if (err_q) begin
                    disp_err_q <= 1'b1;
                end else begin
                    disp_err_q <= 1'b0;
                    hms_bcd_q  <= {1'b0, ht_q, h_q[3:0],
                                   1'b0, mt_q, m_q[3:0],
                                   1'b0, st_q, s_q[3:0]};
                end
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.hms_bcd = hms_bcd_q;

    seg_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk       (clk),
        .reset     (reset),
        .hms_bcd_i (hms_bcd_q),
        .err_i     (disp_err_q),
        .an_o      (bus.an),
        .seg_o     (bus.seg),
        .dp_o      (bus.dp)
    );

endmodule

// File: tb/tb_clock_display.sv
// Scoreboard bench for clock_display: stimulus pushes the expected
// conversion result and latency; a monitor pops on every busy fall.
module tb_clock_display;

    localparam int SECS_W   = 17;
    localparam int SCAN_DIV = 4;

    logic clk = 1'b0;
    logic reset;

    clock_display_if #(.SECS_W(SECS_W)) bus ();

    clock_display #(
        .SECS_W   (SECS_W),
        .SCAN_DIV (SCAN_DIV),
        .DAY_SECS (86400)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] bcd;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;

    // Reference model state
    int          model_captured = 0;
    bit          model_force    = 1'b1;
    logic [23:0] model_bcd      = '0;
    bit          model_err      = 1'b0;

    // Segments lit (active-high, bit0 = A) for decimal digits
    logic [6:0]  lit_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int max3(input int a, input int b, input int c);
        int r = a;
        if (b > r) r = b;
        if (c > r) r = c;
        return r;
    endfunction

    // Expected conversion of one secs value, from plain arithmetic.
    function automatic exp_t model_conv(input int s);
        exp_t e;
        int h, m, sc;
        if (s >= 86400) begin
            e.bcd = model_bcd;
            e.lat = 2;
        end else begin
            h  = s / 3600;
            m  = (s / 60) % 60;
            sc = s % 60;
            e.bcd = {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
            e.lat = 1 + (h + 1) + (m + 1) + (max3(h / 10, m / 10, sc / 10) + 1) + 1;
        end
        return e;
    endfunction

    task automatic push_for(input int s);
        exp_t e;
        e = model_conv(s);
        sb_q.push_back(e);
        if (s >= 86400) begin
            model_err = 1'b1;
        end else begin
            model_bcd = e.bcd;
            model_err = 1'b0;
        end
        model_captured = s;
        model_force    = 1'b0;
    endtask

    task automatic set_secs(input int s);
        @(posedge clk);
        #1;
        bus.secs = SECS_W'(s);
        if (model_force || (s != model_captured))
            push_for(s);
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ((sb_q.size() == 0) && !bus.busy) begin
                repeat (2) @(negedge clk);
                return;
            end
        end
        tests++;
        fails++;
        $display("FAIL drain_timeout: %0d results still pending after 400 cycles", sb_q.size());
        sb_q.delete();
    endtask

    task automatic assert_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb_q.delete();
        model_bcd   = '0;
        model_err   = 1'b0;
        model_force = 1'b1;
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        push_for(int'(bus.secs));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"},   32'(bus.an),      32'hFF);
        check({tag, "_seg"},  32'(bus.seg),     32'h7F);
        check({tag, "_dp"},   32'(bus.dp),      32'h1);
        check({tag, "_hms"},  32'(bus.hms_bcd), 32'h0);
        check({tag, "_busy"}, 32'(bus.busy),    32'h0);
    endtask

    // Sync to the start of digit 0, then check one full 8-digit frame.
    task automatic scan_check(input string tag);
        logic [7:0] prev;
        logic [7:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] dig;
        bit         found = 1'b0;
        int         d;
        for (int i = 0; i < 200 && !found; i++) begin
            prev = bus.an;
            @(negedge clk);
            if ((bus.an == 8'hFE) && (prev != 8'hFE)) found = 1'b1;
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL %s_sync: an never entered 0xFE, last an=0x%0h", tag, bus.an);
            return;
        end
        for (int i = 0; i < 8 * SCAN_DIV; i++) begin
            d = i / SCAN_DIV;
            if (d < 6) begin
                e_an = 8'hFF;
                e_an[d] = 1'b0;
                dig = model_bcd[4*d +: 4];
                if (model_err) begin
                    e_seg = 7'b0111111;
                    e_dp  = 1'b1;
                end else begin
                    e_seg = ~lit_tab[dig];
                    e_dp  = !((d == 2) || (d == 4));
                end
            end else begin
                e_an  = 8'hFF;
                e_seg = 7'h7F;
                e_dp  = 1'b1;
            end
            check($sformatf("%s_an_d%0d", tag, d),  32'(bus.an),  32'(e_an));
            check($sformatf("%s_seg_d%0d", tag, d), 32'(bus.seg), 32'(e_seg));
            check($sformatf("%s_dp_d%0d", tag, d),  32'(bus.dp),  32'(e_dp));
            @(negedge clk);
        end
    endtask

    // Monitor: a busy fall marks a completed conversion.
    bit   prev_busy = 1'b0;
    int   rise_cyc  = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (!reset) begin
            prev_busy = 1'b0;
        end else begin
            if (bus.busy && !prev_busy)
                rise_cyc = cyc;
            if (!bus.busy && prev_busy) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: hms_bcd=0x%0h with no conversion expected", bus.hms_bcd);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("hms_bcd", 32'(bus.hms_bcd), 32'(mon_e.bcd));
                    check("latency", 32'(cyc - rise_cyc + 1), 32'(mon_e.lat));
                end
            end
            prev_busy = bus.busy;
        end
    end

    initial begin
        int s;
        reset    = 1'b0;
        bus.secs = '0;

        // Reset held low: outputs at reset values
        repeat (5) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold_a");
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold_b");
        release_reset();
        drain();

        set_secs(86399); drain();
        set_secs(3661);  drain();
        set_secs(3662);  drain();

        // Out-of-range then recovery
        set_secs(90000); drain();
        scan_check("err");
        set_secs(59);    drain();
        scan_check("t000059");

        set_secs(45296); drain();   // 12:34:56
        scan_check("t123456");

        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 7) == 0)
                s = int'($urandom_range(86400, 131071));
            else
                s = int'($urandom_range(0, 86399));
            set_secs(s);
            drain();
        end
        scan_check("rand");

        // Reset pulse mid-conversion
        set_secs(0);     drain();
        set_secs(86399);
        repeat (20) @(posedge clk);
        assert_reset();
        #1;
        check_reset_outputs("rst_mid");
        repeat (3) @(posedge clk);
        release_reset();
        drain();

        // secs change while busy is converted right after
        set_secs(7322);
        repeat (10) @(posedge clk);
        set_secs(50000);
        drain();
        scan_check("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
